// File: rtl/conv_sched.sv
// conv_sched: single-layer convolution sequencer owning the shared memory port
module conv_sched #(
  parameter int M = 20,
  parameter int N = 9,
  parameter int K = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 'h1000,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 'h2000,
  parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = 'h3000,
  parameter int DRAIN_MAX = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [ADDR_WIDTH-1:0]          mem_addr_rd,
  input  logic [DATA_WIDTH-1:0]          mem_rd_data,
  output logic [ADDR_WIDTH-1:0]          mem_addr_wr,
  output logic [DATA_WIDTH-1:0]          mem_wr_data,
  output logic                           mem_wr_en,
  output logic                           im2col_rst,
  input  logic [ADDR_WIDTH-1:0]          im2col_addr_rd,
  input  logic [ADDR_WIDTH-1:0]          im2col_addr_wr,
  input  logic [DATA_WIDTH-1:0]          im2col_wr_data,
  input  logic                           im2col_wr_en,
  input  logic                           im2col_done,
  output logic                           array_rst,
  output logic                           array_en,
  output logic [DATA_WIDTH*N-1:0]        x_vec,
  output logic [DATA_WIDTH*N*K-1:0]      w_mat,
  input  logic [DATA_WIDTH*K-1:0]        y_vec,
  input  logic                           y_valid
);
  localparam int CW = $clog2(N*K+1);
  localparam int RW = $clog2(M+1);
  localparam int DMW = $clog2(DRAIN_MAX+1);
  typedef enum logic [2:0] {IDLE, IM2COL, LOAD_W, FETCH, STEP, DRAIN, WRITE, FIN} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [RW-1:0] r, o;
  logic [DMW-1:0] d;
  logic [DATA_WIDTH*N-1:0] stage;
  logic [DATA_WIDTH*K-1:0] y_lat;
  logic im_sel, take_y, lw_rd, fr_rd, more_rows;
  assign im_sel = state == IM2COL && !im2col_done;
  assign take_y = y_valid && o < RW'(M);
  assign lw_rd = state == LOAD_W && cnt < CW'(N*K);
  assign fr_rd = state == FETCH && cnt < CW'(N);
  assign more_rows = r < RW'(M-1);
  assign busy = state != IDLE;
  assign done = state == FIN;
  assign im2col_rst = !im_sel;
  assign array_en = state == STEP || state == DRAIN;
  assign array_rst = state == IDLE || state == IM2COL || state == FIN || lw_rd;
  assign x_vec = state == STEP ? stage : '0;
  // Memory port: im2col engine owns it while running, otherwise the sequencer drives it
  always_comb begin
    mem_addr_rd = im_sel ? im2col_addr_rd
                : lw_rd ? WEIGHT_BASE + ADDR_WIDTH'(cnt)
                : fr_rd ? IM2COL_BASE + ADDR_WIDTH'(r) * ADDR_WIDTH'(N) + ADDR_WIDTH'(cnt)
                : '0;
    mem_addr_wr = im_sel ? im2col_addr_wr
                : state == WRITE ? OUTPUT_BASE + ADDR_WIDTH'(o) * ADDR_WIDTH'(K) + ADDR_WIDTH'(cnt)
                : '0;
    mem_wr_data = im_sel ? im2col_wr_data
                : state == WRITE ? y_lat[int'(cnt)*DATA_WIDTH +: DATA_WIDTH]
                : '0;
    mem_wr_en = im_sel ? im2col_wr_en : state == WRITE;
  end
  // Phase sequencing, weight/row capture and result write-back bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      nxt <= IDLE;
      cnt <= '0;
      r <= '0;
      o <= '0;
      d <= '0;
      stage <= '0;
      y_lat <= '0;
      w_mat <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= IM2COL;
          err <= 1'b0;
          cnt <= '0;
          r <= '0;
          o <= '0;
          d <= '0;
        end
        IM2COL: if (im2col_done) begin
          state <= LOAD_W;
          cnt <= '0;
        end
        LOAD_W: begin
          if (cnt != '0) w_mat[(int'(cnt)-1)*DATA_WIDTH +: DATA_WIDTH] <= mem_rd_data;
          cnt <= cnt == CW'(N*K) ? '0 : cnt + 1'b1;
          if (cnt == CW'(N*K)) state <= FETCH;
        end
        FETCH: begin
          if (cnt != '0) stage[(int'(cnt)-1)*DATA_WIDTH +: DATA_WIDTH] <= mem_rd_data;
          cnt <= cnt == CW'(N) ? '0 : cnt + 1'b1;
          if (cnt == CW'(N)) state <= STEP;
        end
        STEP: begin
          nxt <= more_rows ? FETCH : DRAIN;
          if (more_rows) r <= r + 1'b1;
          if (take_y) y_lat <= y_vec;
          state <= take_y ? WRITE : more_rows ? FETCH : DRAIN;
        end
        DRAIN: begin
          d <= d + 1'b1;
          nxt <= DRAIN;
          if (take_y) y_lat <= y_vec;
          if (!take_y && d == DMW'(DRAIN_MAX-1)) err <= 1'b1;
          state <= take_y ? WRITE : d == DMW'(DRAIN_MAX-1) ? FIN : DRAIN;
        end
        WRITE: begin
          cnt <= cnt == CW'(K-1) ? '0 : cnt + 1'b1;
          if (cnt == CW'(K-1)) begin
            o <= o + 1'b1;
            state <= o == RW'(M-1) ? FIN : nxt;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_sched.sv
// tb_conv_sched: directed checks of the conv_sched layer sequencer
module tb_conv_sched;
  localparam int M = 20, N = 9, K = 5, DW = 32, AW = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, err, mem_wr_en, im2col_rst, im2col_wr_en, im2col_done;
  logic array_rst, array_en, y_valid;
  logic [AW-1:0] mem_addr_rd, mem_addr_wr, im2col_addr_rd, im2col_addr_wr;
  logic [DW-1:0] mem_rd_data, mem_wr_data, im2col_wr_data;
  logic [DW*N-1:0] x_vec;
  logic [DW*N*K-1:0] w_mat;
  logic [DW*K-1:0] y_vec;
  logic [DW-1:0] mem [0:16383];
  logic [DW*K-1:0] hist [0:127];
  logic [3:0] ic = '0;
  bit ic_wr = 0, clr_req = 0;
  int mode = 0, acnt = 0;
  int nwr, nbad, ndone, npulse, novl;
  int n_chk = 0, n_pass = 0;

  conv_sched dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .mem_addr_rd(mem_addr_rd), .mem_rd_data(mem_rd_data), .mem_addr_wr(mem_addr_wr),
    .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en), .im2col_rst(im2col_rst),
    .im2col_addr_rd(im2col_addr_rd), .im2col_addr_wr(im2col_addr_wr),
    .im2col_wr_data(im2col_wr_data), .im2col_wr_en(im2col_wr_en), .im2col_done(im2col_done),
    .array_rst(array_rst), .array_en(array_en), .x_vec(x_vec), .w_mat(w_mat),
    .y_vec(y_vec), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [DW*K-1:0] prod(input logic [DW*N-1:0] x, input logic [DW*N*K-1:0] w);
    logic [DW*K-1:0] y = '0;
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++)
        y[k*DW +: DW] = y[k*DW +: DW] + x[j*DW +: DW] * w[(j*K+k)*DW +: DW];
    return y;
  endfunction

  function automatic logic [DW-1:0] expv(input int n);
    int unsigned s = 0;
    int i = n / K, k = n % K;
    for (int j = 0; j < N; j++) s += (32'h2000 + i*N + j) * (j*K + k + 1);
    return s;
  endfunction

  always @(posedge clk) mem_rd_data <= mem[mem_addr_rd[13:0]];

  always @(posedge clk) if (im2col_rst) ic <= '0; else if (ic != 4'hF) ic <= ic + 1'b1;
  assign im2col_done = ic >= 4'd4;
  assign im2col_addr_rd = 32'h2000;
  assign im2col_addr_wr = 32'h2005;
  assign im2col_wr_data = 32'hABCD;
  assign im2col_wr_en = ic_wr && !im2col_rst && ic == 4'd2;

  always @(posedge clk)
    if (array_rst) acnt <= 0;
    else if (array_en) begin
      hist[acnt[6:0]] <= prod(x_vec, w_mat);
      acnt <= acnt + 1;
    end
  assign y_valid = mode == 1 ? 1'b1 : mode == 0 ? acnt >= 2 : 1'b0;
  assign y_vec = mode == 1 ? prod(x_vec, w_mat) : (mode == 0 && acnt >= 2) ? hist[acnt-2] : '0;

  always @(posedge clk)
    if (clr_req) begin
      nwr = 0; nbad = 0; ndone = 0; npulse = 0; novl = 0;
    end else begin
      if (mem_wr_en) begin
        if (mem_addr_wr != 32'h3000 + nwr || mem_wr_data != expv(nwr)) nbad++;
        nwr++;
      end
      if (done) ndone++;
      if (array_en) npulse++;
      if (array_en && mem_wr_en) novl++;
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clr();
    @(negedge clk) clr_req = 1;
    @(negedge clk) clr_req = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_done(input bit extra);
    bit seen = 0, s1 = 0, s2 = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      start = 0;
      if (done) seen = 1;
      else if (extra && !s1 && busy && im2col_rst && array_rst) begin start = 1; s1 = 1; end
      else if (extra && !s2 && mem_wr_en) begin start = 1; s2 = 1; end
    end
    start = 0;
    chk("done_seen", seen, 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_layer(input string tag);
    chk({tag, "_nwr"}, nwr, 100);
    chk({tag, "_nbad"}, nbad, 0);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    bit seen;
    for (int a = 0; a < 16384; a++) mem[a] = '0;
    for (int i = 0; i < N*K; i++) mem[14'h1000 + i] = i + 1;
    for (int i = 0; i < M*N; i++) mem[14'h2000 + i] = 32'h2000 + i;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_addr_rd", mem_addr_rd, 0);
    chk("rst_addr_wr", mem_addr_wr, 0);
    chk("rst_im2col_rst", im2col_rst, 1);
    chk("rst_array_rst", array_rst, 1);
    chk("rst_array_en", array_en, 0);
    chk("rst_x_vec", |x_vec, 0);
    chk("rst_w_mat", |w_mat, 0);
    rst = 0;
    clr();
    pulse_start();
    wait_done(0);
    chk("t1_w44", w_mat[44*DW +: DW], 45);
    chk("t1_err", err, 0);
    chk("t1_npulse", npulse, 22);
    chk_layer("t1");
    clr();
    pulse_start();
    wait_done(1);
    chk_layer("t2");
    ic_wr = 1;
    clr();
    pulse_start();
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (im2col_wr_en) begin
        seen = 1;
        chk("t3_wr_en", mem_wr_en, 1);
        chk("t3_addr_wr", mem_addr_wr, 32'h2005);
        chk("t3_wr_data", mem_wr_data, 32'hABCD);
      end
    end
    chk("t3_seen", seen, 1);
    ic_wr = 0;
    wait_done(0);
    clr();
    pulse_start();
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (mem_wr_en && mem_addr_wr == 32'h3025) seen = 1;
    end
    chk("t4_seen", seen, 1);
    rst = 1;
    @(negedge clk);
    chk("t4_wr_en", mem_wr_en, 0);
    chk("t4_busy", busy, 0);
    chk("t4_array_rst", array_rst, 1);
    chk("t4_im2col_rst", im2col_rst, 1);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("t4_nwr_abort", nwr, 38);
    clr();
    pulse_start();
    wait_done(0);
    chk_layer("t4");
    mode = 2;
    clr();
    pulse_start();
    wait_done(0);
    chk("t5_err", err, 1);
    chk("t5_nwr", nwr, 0);
    chk("t5_ndone", ndone, 1);
    chk("t5_npulse", npulse, 84);
    mode = 0;
    clr();
    pulse_start();
    chk("t5_err_clr", err, 0);
    wait_done(0);
    chk_layer("t5");
    mode = 1;
    clr();
    pulse_start();
    wait_done(0);
    chk_layer("t6");
    chk("t6_novl", novl, 0);
    chk("t6_npulse", npulse, 20);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
